// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM-stage load/store unit.
// Accepts one single-beat request, waits LATENCY cycles, performs a
// byte-masked store or a word load, then pulses valid for one cycle.
// Optional build macro: DMEM_RANGE_CHECK_EN (adds err, blocks out-of-range accesses).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        valid,
  output logic        busy
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept, access;

  // Captured request
  logic            wr_q;
  logic [3:0]      mask_q;
  logic [31:0]     data_q;
  logic [AW-1:0]   idx_q;
  logic            oor_q;

  // Operands of the access performed on the edge entering RESP
  logic            acc_wr;
  logic [3:0]      acc_mask;
  logic [31:0]     acc_data;
  logic [AW-1:0]   acc_idx;
  logic            acc_oor;
  logic            mem_we;

  logic [AW-1:0]   in_idx;
  logic            in_oor;

  logic [31:0]     mem [DEPTH_WORDS];

  assign in_idx = addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  assign in_oor = ({1'b0, addr} >= ADDR_LIMIT);
`else
  assign in_oor = 1'b0;
`endif

  // Byte offset and (in the wrapping build) upper address bits play no role.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // Next-state logic; with LATENCY = 0 the access happens on the accept edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cs) begin
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_nxt = S_RESP;
            access    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          access    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Access operands: live inputs when accessing straight from IDLE, else captured copy.
  always_comb begin
    if (state == S_IDLE) begin
      acc_wr   = wr;
      acc_mask = mask;
      acc_data = data_wr;
      acc_idx  = in_idx;
      acc_oor  = in_oor;
    end else begin
      acc_wr   = wr_q;
      acc_mask = mask_q;
      acc_data = data_q;
      acc_idx  = idx_q;
      acc_oor  = oor_q;
    end
  end

  // A store reaching memory is killed by reset even if it coincides with the edge.
  assign mem_we = access & ~acc_wr & ~acc_oor & ~rst;

  // Byte-lane store into the array (array contents are never reset).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_mask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

  // State, wait counter, request capture and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b1;
      mask_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      data_rd <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q   <= wr;
        mask_q <= mask;
        data_q <= data_wr;
        idx_q  <= in_idx;
        oor_q  <= in_oor;
      end
      if (access && acc_wr) begin
        data_rd <= acc_oor ? '0 : mem[acc_idx];
      end
    end
  end

  assign valid = (state == S_RESP);
  assign busy  = (state != S_IDLE);

`ifdef DMEM_RANGE_CHECK_EN
  assign err = valid & oor_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave that terminates the load/store request interface driven by the pipeline's load/store unit in the MEM stage.
- Accepts a single-beat request (cs, wr, mask, addr, data_wr) and holds it for a programmable number of wait states.
- Performs a byte-masked write or a word read, then returns a one-cycle valid pulse with read data on data_rd.
- Provides busy so the hazard unit can stall the pipeline while an access is in flight.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- LATENCY, 2: wait-state cycles between request acceptance and the memory access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cs  input  1  chip select, active-low; request present when 0.
- wr  input  1  0 = store (write), 1 = load (read).
- mask  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
- addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
- data_wr  input  32  store data, already lane-aligned by the requester.
- data_rd  output  32  full aligned read word; the requester performs byte/halfword extraction.
- valid  output  1  response strobe, high for exactly one cycle per accepted request.
- busy  output  1  high while a request is in flight (WAIT or RESP).

Behaviour:
- Reset (async, any state): state = IDLE, valid = 0, busy = 0, data_rd = 0, wait counter = 0. Any pending request is discarded; a pending write never reaches memory. Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - busy = 0, valid = 0.
  - On a clock edge with cs = 0: register addr, wr, mask and data_wr; load counter = LATENCY.
  - If LATENCY = 0, go to ACCESS-in-RESP (see below); otherwise go to WAIT.
- WAIT:
  - busy = 1. Decrement counter each cycle.
  - On the edge where counter = 1, go to RESP.
  - cs is ignored throughout WAIT; requests are not queued.
- Access, on the edge entering RESP:
  - Write: for each i with mask[i] = 1, write byte lane i of the captured data at the captured word index. Lanes with mask[i] = 0 are unchanged. mask = 0 writes nothing but still responds.
  - Read: data_rd <= memory word at the captured index (registered); mask is ignored.
- RESP:
  - valid = 1 and busy = 1 for one cycle, then unconditionally IDLE.
  - A request presented during RESP is ignored; the requester re-presents it after busy falls.
- Latency, acceptance edge to valid high: LATENCY + 1 cycles.
- Back-to-back throughput: one request per LATENCY + 2 cycles.
- data_rd holds its last read value through writes and idle cycles; it changes only on a read access.
- Address handling:
  - addr[1:0] is ignored; word alignment is the requester's responsibility via mask.
  - Without the optional feature, index bits above log2(DEPTH_WORDS)+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Read-after-write to the same word in successive requests returns the updated data.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - A request whose addr >= DEPTH_WORDS*4 still goes through the WAIT timing, but the write is suppressed (memory unchanged) and a read loads data_rd with 32'h0000_0000.
  - err = 1 exactly in the RESP cycle, coincident with valid.
- Undefined: no err port; out-of-range addresses wrap as described above.

Test Plan:
- Reset/idle: assert rst for 3 cycles mid-WAIT of a store of 32'hDEAD_BEEF to addr 0x10; afterwards data_rd = 0, valid = 0, busy = 0; a read of 0x10 returns the pre-store value.
- Word store then load, LATENCY = 2: store 32'h1234_5678 mask 4'b1111 to 0x40; valid rises 3 cycles after acceptance. Load 0x40 -> data_rd = 32'h1234_5678 with valid; busy is high for 3 cycles per request.
- Byte and halfword lanes:
  - Prefill 0x80 = 32'hFFFF_FFFF.
  - Store data_wr 32'h00AB_0000 mask 4'b0100 -> read returns 32'hFFAB_FFFF.
  - Store 32'h0000_1234 mask 4'b0011 -> read returns 32'hFFAB_1234.
- Mask zero and ignored requests:
  - A store with mask 4'b0000 leaves the word unchanged and still pulses valid once.
  - Holding cs = 0 for 10 continuous cycles with LATENCY = 2 produces accepts on cycles 0, 4 and 8, i.e. exactly one valid per 4 cycles.
- LATENCY = 0 build: a load is accepted and valid rises on the next edge. Wrap: with DEPTH_WORDS = 1024, a store to 0x1000 is observed when reading 0x0000.
- DMEM_RANGE_CHECK_EN build:
  - Store 32'h5555_5555 to 0x1004: err = 1 with valid, and a read of 0x0004 is unchanged.
  - Load 0x2000 -> data_rd = 0, err = 1.
